elevator_call_register: RTL and testbench

- Parametrised successor of the 7-floor button latch.
- Latches hall calls (up/down per floor) and car calls (one per floor) for N floors, and clears them when the car serves them, taking travel direction into account.
- Adds masking of impossible hall calls, a lockout mode, and registered summary outputs (calls above/below/here, pending count) for the direction controller.
- Sits between the button/IO layer and the motion/door controller.

---
 rtl/elevator_call_register_pkg.sv | 22 ++
 rtl/elevator_call_register_call_summary.sv | 53 +++++
 rtl/elevator_call_register.sv | 107 ++++++++++
 tb/tb_elevator_call_register.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_call_register_pkg.sv
// Shared constants and bit-map helpers for the elevator call register.
// Hall calls are packed two bits per floor: up at 2(f-1), down at 2(f-1)+1.
package elevator_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;

  function automatic int hall_up_idx(input int f);
    return 2 * (f - 1);
  endfunction

  function automatic int hall_dn_idx(input int f);
    return 2 * (f - 1) + 1;
  endfunction

endpackage

// File: rtl/elevator_call_register_call_summary.sv
// Combinational aggregation of call vectors relative to the car position.
// The parent feeds next-state vectors so the registered summary matches the calls.
module call_summary
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 7,
  parameter int FLOOR_W    = 3,
  parameter int CNT_W      = $clog2(3 * NUM_FLOORS + 1)
) (
  input  logic [2*NUM_FLOORS-1:0] i_hall,
  input  logic [NUM_FLOORS-1:0]   i_car,
  input  logic [FLOOR_W-1:0]      i_floor,
  output logic                    o_here,
  output logic                    o_above,
  output logic                    o_below,
  output logic [CNT_W-1:0]        o_count
);

  logic [NUM_FLOORS-1:0] w_floor_any;
  logic                  w_valid;

  assign w_valid = (i_floor >= FLOOR_W'(1)) && (i_floor <= FLOOR_W'(NUM_FLOORS));

  always_comb begin
    w_floor_any = '0;
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      w_floor_any[f-1] = i_hall[hall_up_idx(f)] | i_hall[hall_dn_idx(f)] | i_car[f-1];
    end
  end

  // An invalid floor (between floors) reports no position-relative calls.
  always_comb begin
    o_here  = OFF;
    o_above = OFF;
    o_below = OFF;
    if (w_valid) begin
      for (int f = 1; f <= NUM_FLOORS; f++) begin
        if (w_floor_any[f-1]) begin
          if (FLOOR_W'(f) == i_floor)     o_here  = ON;
          else if (FLOOR_W'(f) > i_floor) o_above = ON;
          else                            o_below = ON;
        end
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int k = 0; k < 2 * NUM_FLOORS; k++) o_count = o_count + CNT_W'(i_hall[k]);
    for (int k = 0; k < NUM_FLOORS; k++)     o_count = o_count + CNT_W'(i_car[k]);
  end

endmodule

// File: rtl/elevator_call_register.sv
// Latches hall and car calls, clears them as the car serves each floor, and
// registers position summaries for the direction controller.
module elevator_call_register
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 7,
  parameter int FLOOR_W    = 3,
  parameter int CNT_W      = $clog2(3 * NUM_FLOORS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FLOOR_W-1:0]      current_floor,
  input  logic [1:0]              current_direction,
  input  logic                    door_open,
  input  logic                    move,
  input  logic                    lockout,
  input  logic [2*NUM_FLOORS-1:0] hall_press,
  input  logic [NUM_FLOORS-1:0]   car_press,
  output logic [2*NUM_FLOORS-1:0] hall_call,
  output logic [NUM_FLOORS-1:0]   car_call,
  output logic                    call_here,
  output logic                    call_above,
  output logic                    call_below,
  output logic [CNT_W-1:0]        pending_count
);

  logic [2*NUM_FLOORS-1:0] r_hall;
  logic [NUM_FLOORS-1:0]   r_car;
  logic                    r_here;
  logic                    r_above;
  logic                    r_below;
  logic [CNT_W-1:0]        r_count;

  logic [2*NUM_FLOORS-1:0] w_hall_nxt;
  logic [NUM_FLOORS-1:0]   w_car_nxt;
  logic                    w_here;
  logic                    w_above;
  logic                    w_below;
  logic [CNT_W-1:0]        w_count;

  // Clears are applied after the presses so a simultaneous press is served at once.
  always_comb begin
    w_hall_nxt = r_hall | hall_press;
    w_car_nxt  = r_car | car_press;
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (current_floor == FLOOR_W'(f)) begin
        if (door_open == OPEN) begin
          case (current_direction)
            DIR_UP:   w_hall_nxt[hall_up_idx(f)] = OFF;
            DIR_DOWN: w_hall_nxt[hall_dn_idx(f)] = OFF;
            default: begin
              w_hall_nxt[hall_up_idx(f)] = OFF;
              w_hall_nxt[hall_dn_idx(f)] = OFF;
            end
          endcase
        end
        if (door_open == OPEN || move == OFF) w_car_nxt[f-1] = OFF;
      end
    end
    w_hall_nxt[hall_up_idx(NUM_FLOORS)] = OFF;
    w_hall_nxt[hall_dn_idx(1)]          = OFF;
    if (lockout == ON) begin
      w_hall_nxt = '0;
      w_car_nxt  = '0;
    end
  end

  call_summary #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W),
    .CNT_W      (CNT_W)
  ) u_summary (
    .i_hall  (w_hall_nxt),
    .i_car   (w_car_nxt),
    .i_floor (current_floor),
    .o_here  (w_here),
    .o_above (w_above),
    .o_below (w_below),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hall  <= '0;
      r_car   <= '0;
      r_here  <= OFF;
      r_above <= OFF;
      r_below <= OFF;
      r_count <= '0;
    end else begin
      r_hall  <= w_hall_nxt;
      r_car   <= w_car_nxt;
      r_here  <= w_here;
      r_above <= w_above;
      r_below <= w_below;
      r_count <= w_count;
    end
  end

  assign hall_call     = r_hall;
  assign car_call      = r_car;
  assign call_here     = r_here;
  assign call_above    = r_above;
  assign call_below    = r_below;
  assign pending_count = r_count;

endmodule

// File: tb/tb_elevator_call_register.sv
// Directed vector table plus randomized run against a per-floor call model.
module tb_elevator_call_register;

  localparam int N = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cf;
  logic [1:0]  dir;
  logic        door, mv, lock;
  logic [13:0] hp;
  logic [6:0]  cp;
  logic [13:0] hall_call;
  logic [6:0]  car_call;
  logic        call_here, call_above, call_below;
  logic [4:0]  pending_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  elevator_call_register dut (
    .clk               (clk),
    .reset             (rst_n),
    .current_floor     (cf),
    .current_direction (dir),
    .door_open         (door),
    .move              (mv),
    .lockout           (lock),
    .hall_press        (hp),
    .car_press         (cp),
    .hall_call         (hall_call),
    .car_call          (car_call),
    .call_here         (call_here),
    .call_above        (call_above),
    .call_below        (call_below),
    .pending_count     (pending_count)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  cf;
    logic [1:0]  dir;
    logic        door, mv, lock;
    logic [13:0] hp;
    logic [6:0]  cp;
    logic [13:0] e_hall;
    logic [6:0]  e_car;
    logic        e_here, e_above, e_below;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic [2:0] f, logic [1:0] d, logic dr, logic m, logic l,
                              logic [13:0] h, logic [6:0] c, logic [13:0] eh, logic [6:0] ec,
                              logic ehe, logic eab, logic ebe, logic [4:0] en);
    vec_t v;
    v.rst = r; v.cf = f; v.dir = d; v.door = dr; v.mv = m; v.lock = l; v.hp = h; v.cp = c;
    v.e_hall = eh; v.e_car = ec; v.e_here = ehe; v.e_above = eab; v.e_below = ebe; v.e_cnt = en;
    return v;
  endfunction

  // Reference model: one flag per floor and call kind.
  logic m_up [1:N];
  logic m_dn [1:N];
  logic m_car[1:N];

  task automatic model_step();
    logic at, up_srv, dn_srv, car_srv;
    for (int f = 1; f <= N; f++) begin
      at      = (int'(cf) == f);
      up_srv  = at && door && (dir != 2'b10);
      dn_srv  = at && door && (dir != 2'b01);
      car_srv = at && (door || !mv);
      if (!rst_n || lock) begin
        m_up[f] = 1'b0; m_dn[f] = 1'b0; m_car[f] = 1'b0;
      end else begin
        m_up[f]  = (f != N) && !up_srv && (m_up[f] || hp[2*f-2]);
        m_dn[f]  = (f != 1) && !dn_srv && (m_dn[f] || hp[2*f-1]);
        m_car[f] = !car_srv && (m_car[f] || cp[f-1]);
      end
    end
  endtask

  task automatic model_expect(output logic [13:0] eh, output logic [6:0] ec, output logic ehere,
                              output logic eab, output logic ebe, output logic [4:0] ecnt);
    int n;
    eh = '0; ec = '0; ehere = 0; eab = 0; ebe = 0; n = 0;
    for (int f = 1; f <= N; f++) begin
      eh[2*f-2] = m_up[f];
      eh[2*f-1] = m_dn[f];
      ec[f-1]   = m_car[f];
      n += int'(m_up[f]) + int'(m_dn[f]) + int'(m_car[f]);
      if ((m_up[f] || m_dn[f] || m_car[f]) && cf >= 1 && int'(cf) <= N) begin
        if (f == int'(cf)) ehere = 1;
        else if (f > int'(cf)) eab = 1;
        else ebe = 1;
      end
    end
    ecnt = 5'(n);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic [13:0] eh, logic [6:0] ec, logic ehe,
                         logic eab, logic ebe, logic [4:0] en);
    chk({tag, ".hall"},  32'(hall_call),     32'(eh));
    chk({tag, ".car"},   32'(car_call),      32'(ec));
    chk({tag, ".here"},  32'(call_here),     32'(ehe));
    chk({tag, ".above"}, 32'(call_above),    32'(eab));
    chk({tag, ".below"}, 32'(call_below),    32'(ebe));
    chk({tag, ".count"}, 32'(pending_count), 32'(en));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [13:0] eh;
    logic [6:0]  ec;
    logic        ehe, eab, ebe;
    logic [4:0]  en;

    rst_n = 0; cf = 0; dir = 0; door = 0; mv = 1; lock = 0; hp = '0; cp = '0;
    for (int f = 1; f <= N; f++) begin m_up[f] = 0; m_dn[f] = 0; m_car[f] = 0; end

    //            rst cf dir dr mv lk hp        cp       | hall      car      he ab be cnt
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 14'h3FFF, 7'h7F,     14'h0000, 7'h00,   0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 14'h3FFF, 7'h7F,     14'h0000, 7'h00,   0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 0, 14'h0000, 7'h10,     14'h0000, 7'h10,   0, 0, 0, 1));
    vt.push_back(mk(1, 5, 0, 0, 0, 0, 14'h0000, 7'h00,     14'h0000, 7'h00,   0, 0, 0, 0));
    vt.push_back(mk(1, 3, 0, 0, 1, 0, 14'h1002, 7'h00,     14'h0000, 7'h00,   0, 0, 0, 0));
    vt.push_back(mk(1, 3, 0, 0, 1, 0, 14'h0001, 7'h00,     14'h0001, 7'h00,   0, 0, 1, 1));
    vt.push_back(mk(1, 3, 0, 0, 1, 0, 14'h00C0, 7'h00,     14'h00C1, 7'h00,   0, 1, 1, 3));
    vt.push_back(mk(1, 4, 1, 1, 1, 0, 14'h0000, 7'h00,     14'h0081, 7'h00,   1, 0, 1, 2));
    vt.push_back(mk(1, 4, 0, 1, 1, 0, 14'h0000, 7'h00,     14'h0001, 7'h00,   0, 0, 1, 1));
    vt.push_back(mk(1, 0, 0, 0, 1, 0, 14'h0004, 7'h02,     14'h0005, 7'h02,   0, 0, 0, 3));
    vt.push_back(mk(1, 2, 0, 0, 0, 0, 14'h0000, 7'h02,     14'h0005, 7'h00,   1, 0, 1, 2));
    vt.push_back(mk(1, 2, 0, 0, 0, 0, 14'h0000, 7'h02,     14'h0005, 7'h00,   1, 0, 1, 2));
    vt.push_back(mk(1, 2, 0, 0, 1, 0, 14'h0000, 7'h02,     14'h0005, 7'h02,   1, 0, 1, 3));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 14'h0000, 7'h00,     14'h0005, 7'h02,   0, 0, 0, 3));
    vt.push_back(mk(1, 0, 0, 0, 1, 0, 14'h2900, 7'h41,     14'h2905, 7'h43,   0, 0, 0, 8));
    vt.push_back(mk(1, 0, 0, 0, 1, 1, 14'h3FFF, 7'h7F,     14'h0000, 7'h00,   0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 1, 14'h3FFF, 7'h7F,     14'h0000, 7'h00,   0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 1, 14'h3FFF, 7'h7F,     14'h0000, 7'h00,   0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 0, 14'h0010, 7'h00,     14'h0010, 7'h00,   0, 0, 0, 1));
    vt.push_back(mk(0, 3, 0, 0, 1, 0, 14'h3FFF, 7'h7F,     14'h0000, 7'h00,   0, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rst; cf = vt[i].cf; dir = vt[i].dir; door = vt[i].door;
      mv = vt[i].mv; lock = vt[i].lock; hp = vt[i].hp; cp = vt[i].cp;
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].e_hall, vt[i].e_car, vt[i].e_here,
              vt[i].e_above, vt[i].e_below, vt[i].e_cnt);
    end

    // Held up press at floor 6 while its clear condition is active, then door closes.
    rst_n = 1; cf = 6; dir = 2'b01; door = 1; mv = 0; lock = 0; hp = 14'h0400; cp = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("held%0d.hall", i), 32'(hall_call), 32'h0);
    end
    door = 0;
    tick();
    chk("held_release.hall", 32'(hall_call), 32'h0400);
    chk("held_release.here", 32'(call_here), 32'h1);
    chk("held_release.count", 32'(pending_count), 32'h1);

    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      lock  = ($urandom_range(0, 15) == 0);
      cf    = 3'($urandom_range(0, 7));
      dir   = 2'($urandom);
      door  = 1'($urandom);
      mv    = 1'($urandom);
      hp    = 14'($urandom & $urandom & $urandom);
      cp    = 7'($urandom & $urandom);
      tick();
      model_expect(eh, ec, ehe, eab, ebe, en);
      chk_all($sformatf("rnd%0d", i), eh, ec, ehe, eab, ebe, en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
